// File: rtl/servo_pwm_decoder_if.sv
// rtl/servo_pwm_decoder_if.sv - servo PWM decoder signal bundle
interface servo_pwm_decoder_if;
  logic        pwm_in;
  logic [7:0]  angle;
  logic [19:0] width;
  logic        valid;
  logic        range_err;
  logic        signal_lost;

  modport master (
    output pwm_in,
    input  angle, width, valid, range_err, signal_lost
  );

  modport slave (
    input  pwm_in,
    output angle, width, valid, range_err, signal_lost
  );
endinterface

// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - servo PWM high-time decoder with range and loss-of-signal flags
module servo_pwm_decoder #(
  parameter int MIN_PULSE   = 50000,
  parameter int MAX_PULSE   = 100000,
  parameter int CYC_PER_DEG = 278,
  parameter int GLITCH      = 25000,
  parameter int TIMEOUT     = 1250000
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  servo_pwm_decoder_if.slave  bus
);

  // Frame/high-run counters must hold TIMEOUT and also accept a 20-bit width plus one.
  localparam int CW = ($clog2(TIMEOUT + 1) > 21) ? $clog2(TIMEOUT + 1) : 21;
  // Sub-degree counter runs 0..CYC_PER_DEG-1.
  localparam int SW = (CYC_PER_DEG > 1) ? $clog2(CYC_PER_DEG) : 1;

  localparam logic [19:0]   HI_SAT    = '1;
  localparam logic [19:0]   MIN_C     = 20'(MIN_PULSE);
  localparam logic [19:0]   MAX_C     = 20'(MAX_PULSE);
  localparam logic [19:0]   GLITCH_C  = 20'(GLITCH);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [SW-1:0] CPD_M1    = SW'(CYC_PER_DEG - 1);
  localparam logic [7:0]    DEG_MAX   = 8'd180;

  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, HIGH} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [19:0]   hi_cnt_q, hi_cnt_d;
  logic [CW-1:0] run_q, run_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [7:0]    deg_q, deg_d;
  logic          done_q, done_d;
  logic [CW-1:0] frame_q, frame_d;
  logic [7:0]    angle_q, angle_d;
  logic [19:0]   width_q, width_d;
  logic          valid_q, valid_d;
  logic          range_err_q, range_err_d;
  logic          lost_q, lost_d;

  logic level;
  logic rise;
  logic hi_timeout;

  // Synchronizer and edge-detector next values; level is the synchronized line.
  always_comb begin
    sync_d = {sync_q[0], bus.pwm_in};
    prev_d = sync_q[1];
    level  = sync_q[1];
    rise   = sync_q[1] & ~prev_q;
  end

  // Pulse FSM: measures high time and tracks whole degrees above MIN_PULSE without a divider.
  always_comb begin
    state_d    = state_q;
    hi_cnt_d   = hi_cnt_q;
    run_d      = run_q;
    sub_d      = sub_q;
    deg_d      = deg_q;
    done_d     = 1'b0;
    hi_timeout = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        if (!level) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d  = HIGH;
          hi_cnt_d = 20'd1;
          run_d    = CW'(1);
          sub_d    = '0;
          deg_d    = '0;
        end
      end
      HIGH: begin
        if (!level) begin
          state_d = WAIT_RISE;
          done_d  = (hi_cnt_q >= GLITCH_C);
        end else begin
          run_d = run_q + CW'(1);
          if (hi_cnt_q != HI_SAT) hi_cnt_d = hi_cnt_q + 20'd1;
          if (hi_cnt_d > MIN_C) begin
            if (sub_q == CPD_M1) begin
              sub_d = '0;
              if (deg_q != DEG_MAX) deg_d = deg_q + 8'd1;
            end else begin
              sub_d = sub_q + SW'(1);
            end
          end
          // A line stuck high is treated as loss of signal; its eventual fall is ignored.
          if (run_d >= TIMEOUT_C) begin
            hi_timeout = 1'b1;
            state_d    = WAIT_LOW;
          end
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  // Result registers, frame timer and loss-of-signal flag, updated the cycle after an accepted fall.
  always_comb begin
    angle_d     = angle_q;
    width_d     = width_q;
    range_err_d = range_err_q;
    valid_d     = done_q;
    frame_d     = frame_q;
    lost_d      = lost_q;
    if (done_q) begin
      width_d     = hi_cnt_q;
      range_err_d = (hi_cnt_q < MIN_C) || (hi_cnt_q > MAX_C);
      if (hi_cnt_q <= MIN_C)      angle_d = 8'd0;
      else if (hi_cnt_q >= MAX_C) angle_d = DEG_MAX;
      else                        angle_d = deg_q;
    end
    // Restart the frame timer from the accepted pulse's rise (elapsed = width + 1).
    if (done_q)                   frame_d = CW'(hi_cnt_q) + CW'(1);
    else if (frame_q < TIMEOUT_C) frame_d = frame_q + CW'(1);
    if (done_q)                                  lost_d = 1'b0;
    else if ((frame_d >= TIMEOUT_C) || hi_timeout) lost_d = 1'b1;
  end

  // State registers with synchronous active-low reset; sync flops reset high so a pulse in flight is skipped.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q     <= WAIT_LOW;
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      hi_cnt_q    <= '0;
      run_q       <= '0;
      sub_q       <= '0;
      deg_q       <= '0;
      done_q      <= 1'b0;
      frame_q     <= '0;
      angle_q     <= '0;
      width_q     <= '0;
      valid_q     <= 1'b0;
      range_err_q <= 1'b0;
      lost_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      hi_cnt_q    <= hi_cnt_d;
      run_q       <= run_d;
      sub_q       <= sub_d;
      deg_q       <= deg_d;
      done_q      <= done_d;
      frame_q     <= frame_d;
      angle_q     <= angle_d;
      width_q     <= width_d;
      valid_q     <= valid_d;
      range_err_q <= range_err_d;
      lost_q      <= lost_d;
    end
  end

  assign bus.angle       = angle_q;
  assign bus.width       = width_q;
  assign bus.valid       = valid_q;
  assign bus.range_err   = range_err_q;
  assign bus.signal_lost = lost_q;

endmodule
